seq_div_8by4: RTL
=================

SEQ_DIV_8BY4 -- requirements
Module: seq_div_8by4

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin a division; sampled only in IDLE.
REQ-005 dividend  input  8  unsigned dividend, captured on the accepted start edge.
REQ-006 divisor  input  4  unsigned divisor, captured on the accepted start edge.
REQ-007 quot  output  8  unsigned quotient, registered.
REQ-008 rem  output  4  unsigned remainder, registered.
REQ-009 busy  output  1  high while an operation is in progress (CALC state).
REQ-010 done  output  1  single-cycle pulse; quot/rem valid while high and held until the next accepted start.
REQ-011 div_by_zero  output  1  high with done when the captured divisor was zero.

Function
REQ-012 FSM states SHALL be IDLE, CALC, DONE; encoding free.
REQ-013 IDLE: start=1 at edge k SHALL latch the operands, clear the partial remainder r[3:0], set the iteration count to 7, and move to CALC.
REQ-014 start SHALL be ignored in CALC and DONE; the latched operands SHALL NOT change.
REQ-015 Each CALC edge SHALL form trial={r,next dividend bit}, taking dividend bits MSB first (5 bits).
REQ-016 If trial>={1'b0,divisor}, that edge SHALL write r=(trial-divisor)[3:0] and quotient bit=1; otherwise r=trial[3:0] and quotient bit=0.
REQ-017 Quotient bits SHALL be produced MSB first, one per edge; edges k+1..k+8 SHALL complete the 8 iterations.
REQ-018 Edge k+8 SHALL move to DONE and load quot/rem, so done=1 during the cycle after edge k+8; total latency is 9 edges from the accepted start.
REQ-019 DONE SHALL return to IDLE on the next edge unconditionally; the earliest next accepted start is edge k+10.
REQ-020 busy SHALL be 1 exactly in CALC; done SHALL be 1 exactly in DONE.
REQ-021 quot/rem/div_by_zero SHALL be updated only on entry to DONE and otherwise SHALL hold.
REQ-022 The result SHALL satisfy dividend==quot*divisor+rem with rem<divisor for every nonzero divisor.
REQ-023 A zero divisor SHALL yield quot=8'hFF and rem=dividend[3:0].

Reset
REQ-024 reset=1 SHALL force IDLE immediately, independent of clk, and abort any operation in progress.
REQ-025 During reset, quot=0, rem=0, busy=0, done=0, div_by_zero=0, and the internal r and count SHALL be 0.
REQ-026 After reset deasserts, the first rising edge with start=1 SHALL be accepted normally.

Configuration
REQ-027 Macro DIV_BYZERO_CHECK_EN SHALL control zero-divisor short-circuiting.
REQ-028 With DIV_BYZERO_CHECK_EN defined, an accepted start with divisor==0 SHALL go IDLE->DONE on edge k+1 with busy never asserted.
REQ-029 In that short-circuit case, quot=8'hFF, rem=dividend[3:0], and div_by_zero=1 with done.
REQ-030 Without DIV_BYZERO_CHECK_EN, a zero divisor SHALL run the normal 8-iteration path with the REQ-018 latency, giving the REQ-023 result, and div_by_zero SHALL be tied 0.

Verification
REQ-031 dividend=200, divisor=7, start at edge k -> busy for 8 cycles, done at cycle after k+8, quot=28, rem=4.
REQ-032 255/15 -> quot=17, rem=0; 5/9 -> quot=0, rem=5; 0/1 -> quot=0, rem=0.
REQ-033 Start 100/3, then pulse start with 50/5 during CALC -> the second request is ignored; quot=33, rem=1.
REQ-034 Divide 77 by 0 -> with macro: done at edge k+1, quot=8'hFF, rem=4'hD, div_by_zero=1; without macro: done after 9 edges, same quot/rem, div_by_zero=0.
REQ-035 Assert reset asynchronously mid-CALC -> all outputs 0 immediately; the next start of 9/2 gives quot=4, rem=1.
REQ-036 Exhaustive sweep of all 4096 operand pairs with back-to-back starts -> REQ-022 holds for every nonzero divisor and REQ-023 holds for every zero divisor.

Source files
------------

// File: rtl/seq_div_8by4.sv
// seq_div_8by4 -- sequential 8-bit by 4-bit unsigned restoring divider.
//
// Produces one quotient bit per clock, MSB first, over eight CALC cycles.
// The result is loaded into quot/rem on the eighth iteration, and done pulses
// for one cycle while the result is valid. The result is held until the next
// accepted start.
//
// Optional feature (macro DIV_BYZERO_CHECK_EN):
//   defined   - a zero divisor skips CALC. The block goes straight to DONE with
//               quot=8'hFF, rem=dividend[3:0] and div_by_zero=1.
//   undefined - a zero divisor runs the normal iterations, which naturally
//               yield quot=8'hFF and rem=dividend[3:0]. div_by_zero is tied 0.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-high reset
//   start        in   begin a division (only sampled in IDLE)
//   dividend[7:0] in  unsigned dividend, captured on accepted start
//   divisor[3:0]  in  unsigned divisor, captured on accepted start
//   quot[7:0]    out  registered quotient
//   rem[3:0]     out  registered remainder
//   busy         out  high in CALC
//   done         out  one-cycle pulse in DONE, result valid
//   div_by_zero  out  high with done when the divisor was zero
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; outputs hold the last result
// CALC   | one restoring-division iteration per cycle, 8 cycles
// DONE   | result valid, done high; returns to IDLE next cycle

module seq_div_8by4 (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] dividend,
    input  logic [3:0] divisor,
    output logic [7:0] quot,
    output logic [3:0] rem,
    output logic       busy,
    output logic       done,
    output logic       div_by_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] dvd_sh;     // dividend, shifted left; bit 7 is the next bit
    logic [3:0] dvs;
    logic [3:0] r;
    logic [2:0] count;
    logic [7:0] q;

    logic [4:0] trial;
    logic [4:0] diff;
    logic       ge;
    logic [3:0] r_next;
    logic [7:0] q_next;

    // The partial remainder always stays below the divisor, so 4 bits are
    // enough. With a zero divisor, every trial passes. That shifts the
    // dividend through r and sets every quotient bit.
    always_comb begin
        trial  = {r, dvd_sh[7]};
        diff   = trial - {1'b0, dvs};
        ge     = (trial >= {1'b0, dvs});
        r_next = ge ? diff[3:0] : trial[3:0];
        q_next = {q[6:0], ge};
    end

`ifdef DIV_BYZERO_CHECK_EN
    logic dbz_q;
    assign div_by_zero = dbz_q;
`else
    assign div_by_zero = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            dvd_sh <= 8'd0;
            dvs    <= 4'd0;
            r      <= 4'd0;
            count  <= 3'd0;
            q      <= 8'd0;
            quot   <= 8'd0;
            rem    <= 4'd0;
            busy   <= 1'b0;
            done   <= 1'b0;
`ifdef DIV_BYZERO_CHECK_EN
            dbz_q  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        dvd_sh <= dividend;
                        dvs    <= divisor;
                        r      <= 4'd0;
                        count  <= 3'd7;
                        q      <= 8'd0;
`ifdef DIV_BYZERO_CHECK_EN
                        if (divisor == 4'd0) begin
                            state <= S_DONE;
                            quot  <= 8'hFF;
                            rem   <= dividend[3:0];
                            dbz_q <= 1'b1;
                            done  <= 1'b1;
                        end else begin
                            state <= S_CALC;
                            busy  <= 1'b1;
                        end
`else
                        state <= S_CALC;
                        busy  <= 1'b1;
`endif
                    end
                end

                S_CALC: begin
                    r      <= r_next;
                    q      <= q_next;
                    dvd_sh <= {dvd_sh[6:0], 1'b0};
                    count  <= count - 3'd1;
                    if (count == 3'd0) begin
                        // Last iteration: publish the result directly from
                        // this cycle's values rather than waiting a cycle.
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        quot  <= q_next;
                        rem   <= r_next;
`ifdef DIV_BYZERO_CHECK_EN
                        dbz_q <= 1'b0;
`endif
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
